// File: rtl/risc_processor.sv
// risc_processor: 16-bit single-cycle RISC core with a built-in GCD program.
// Hierarchy: risc_processor -> dpath (risc_datapath) -> {rbank, dmem}.

// Register bank: three combinational read ports and one synchronous write port.
module risc_regbank #(
  parameter int DATA_W = 16,
  parameter int NREGS  = 8,
  parameter int RA_W   = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [RA_W-1:0]   waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [RA_W-1:0]   ra,
  input  logic [RA_W-1:0]   rb,
  input  logic [RA_W-1:0]   rc,
  output logic [DATA_W-1:0] rd_a,
  output logic [DATA_W-1:0] rd_b,
  output logic [DATA_W-1:0] rd_c
);
  // Declaration value gives the cleared power-up state without a reset pulse.
  logic [DATA_W-1:0] regfile [0:NREGS-1] = '{default: '0};

  // Write port: reset clears every register, r0 is never written.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses <= so every register samples pre-edge values.
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regfile[i] <= '0;
    end else if (we && (waddr != '0)) begin
      regfile[waddr] <= wdata;
    end
  end

  // Read ports: r0 is hardwired to zero.
  always_comb begin
    rd_a = (ra == '0) ? '0 : regfile[ra];
    rd_b = (rb == '0) ? '0 : regfile[rb];
    rd_c = (rc == '0) ? '0 : regfile[rc];
  end
endmodule

// Data memory: one synchronous write port, a load port and a debug port, both combinational.
module risc_dmem #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 10,
  parameter int OP_A_INIT = 48,
  parameter int OP_B_INIT = 18
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] dmem [0:DEPTH-1] =
    '{0: DATA_W'(OP_A_INIT), 1: DATA_W'(OP_B_INIT), default: '0};

  // Store port; reset reloads only the two operands and the result word.
  always_ff @(posedge clk) begin
    // NOTE: only words 0..2 are reset; the rest of the memory keeps its contents.
    if (reset) begin
      dmem[0] <= DATA_W'(OP_A_INIT);
      dmem[1] <= DATA_W'(OP_B_INIT);
      dmem[2] <= '0;
    end else if (we) begin
      dmem[waddr] <= wdata;
    end
  end

  // Asynchronous reads for loads and for the debug port.
  always_comb begin
    rdata    = dmem[raddr];
    dbg_data = dmem[dbg_addr];
  end
endmodule

// Datapath: PC, instruction ROM, decode, ALU, branch logic, register bank and data memory.
module risc_datapath #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 10,
  parameter int NREGS     = 8,
  parameter int OP_A_INIT = 48,
  parameter int OP_B_INIT = 18
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] inaddress,
  output logic [DATA_W-1:0] outdata
);
  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,  OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR  = 4'd3,
    OP_SLT  = 4'd4,  OP_ADDI = 4'd5, OP_LW = 4'd6, OP_SW  = 4'd7,
    OP_BEQ  = 4'd8,  OP_BNE = 4'd9, OP_J   = 4'd10, OP_HALT = 4'd15
  } opcode_e;

  logic [ADDR_W-1:0] pc     = '0;
  logic              halted = 1'b0;

  logic [15:0]       instr;
  logic [3:0]        op;
  logic [2:0]        fa, fb, fc;
  logic [DATA_W-1:0] imm;
  logic [ADDR_W-1:0] jtarget;
  logic [DATA_W-1:0] rd_a, rd_b, rd_c, mem_rdata, wb_data;
  logic [ADDR_W-1:0] pc_inc, pc_next, mem_addr;
  logic              reg_we, mem_we, halt_now;

  // GCD program ROM; any address past the program fetches HALT.
  always_comb begin
    case (pc)
      10'd0:   instr = {OP_LW,   3'd1, 3'd0, 6'd0};        // LW  r1,0(r0)
      10'd1:   instr = {OP_LW,   3'd2, 3'd0, 6'd1};        // LW  r2,1(r0)
      10'd2:   instr = {OP_BEQ,  3'd1, 3'd2, 6'd6};        // BEQ r1,r2,+6
      10'd3:   instr = {OP_SLT,  3'd3, 3'd2, 3'd1, 3'd0};  // SLT r3,r2,r1
      10'd4:   instr = {OP_BNE,  3'd3, 3'd0, 6'd2};        // BNE r3,r0,+2
      10'd5:   instr = {OP_SUB,  3'd2, 3'd2, 3'd1, 3'd0};  // SUB r2,r2,r1
      10'd6:   instr = {OP_J,    12'd2};                   // J   2
      10'd7:   instr = {OP_SUB,  3'd1, 3'd1, 3'd2, 3'd0};  // SUB r1,r1,r2
      10'd8:   instr = {OP_J,    12'd2};                   // J   2
      10'd9:   instr = {OP_SW,   3'd1, 3'd0, 6'd2};        // SW  r1,2(r0)
      default: instr = {OP_HALT, 12'd0};
    endcase
  end

  // Field extraction and immediate sign extension.
  always_comb begin
    op      = instr[15:12];
    fa      = instr[11:9];
    fb      = instr[8:6];
    fc      = instr[5:3];
    imm     = {{(DATA_W-6){instr[5]}}, instr[5:0]};
    jtarget = instr[ADDR_W-1:0];
  end

  // Execute: ALU result, write enables and next PC for the current instruction.
  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    wb_data  = '0;
    reg_we   = 1'b0;
    mem_we   = 1'b0;
    halt_now = 1'b0;
    pc_inc   = pc + ADDR_W'(1);
    pc_next  = pc_inc;
    mem_addr = rd_b[ADDR_W-1:0] + imm[ADDR_W-1:0];
    case (op)
      OP_ADD:  begin wb_data = rd_b + rd_c; reg_we = 1'b1; end
      OP_SUB:  begin wb_data = rd_b - rd_c; reg_we = 1'b1; end
      OP_AND:  begin wb_data = rd_b & rd_c; reg_we = 1'b1; end
      OP_OR:   begin wb_data = rd_b | rd_c; reg_we = 1'b1; end
      OP_SLT:  begin
        wb_data = {{(DATA_W-1){1'b0}}, ($signed(rd_b) < $signed(rd_c))};
        reg_we  = 1'b1;
      end
      OP_ADDI: begin wb_data = rd_b + imm; reg_we = 1'b1; end
      OP_LW:   begin wb_data = mem_rdata; reg_we = 1'b1; end
      OP_SW:   mem_we = 1'b1;
      OP_BEQ:  if (rd_a == rd_b) pc_next = pc_inc + imm[ADDR_W-1:0];
      OP_BNE:  if (rd_a != rd_b) pc_next = pc_inc + imm[ADDR_W-1:0];
      OP_J:    pc_next = jtarget;
      OP_HALT: begin pc_next = pc; halt_now = 1'b1; end
      default: ;
    endcase
    if (halted) begin
      reg_we  = 1'b0;
      mem_we  = 1'b0;
      pc_next = pc;
    end
  end

  // Commit the next PC and hold the halt state until reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc     <= '0;
      halted <= 1'b0;
    end else begin
      pc <= pc_next;
      if (halt_now) halted <= 1'b1;
    end
  end

  risc_regbank #(.DATA_W(DATA_W), .NREGS(NREGS)) rbank (
    .clk   (clk),
    .reset (reset),
    .we    (reg_we),
    .waddr (fa),
    .wdata (wb_data),
    .ra    (fa),
    .rb    (fb),
    .rc    (fc),
    .rd_a  (rd_a),
    .rd_b  (rd_b),
    .rd_c  (rd_c)
  );

  risc_dmem #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .OP_A_INIT(OP_A_INIT), .OP_B_INIT(OP_B_INIT)
  ) dmem (
    .clk      (clk),
    .reset    (reset),
    .we       (mem_we),
    .waddr    (mem_addr),
    .wdata    (rd_a),
    .raddr    (mem_addr),
    .rdata    (mem_rdata),
    .dbg_addr (inaddress),
    .dbg_data (outdata)
  );
endmodule

// Top level: processor with a combinational debug read port into data memory.
module risc_processor #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 10,
  parameter int NREGS     = 8,
  parameter int OP_A_INIT = 48,
  parameter int OP_B_INIT = 18
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] inaddress,
  output logic [DATA_W-1:0] outdata
);
  risc_datapath #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREGS(NREGS),
    .OP_A_INIT(OP_A_INIT), .OP_B_INIT(OP_B_INIT)
  ) dpath (
    .clk       (clk),
    .reset     (reset),
    .inaddress (inaddress),
    .outdata   (outdata)
  );
endmodule

// File: tb/tb_risc_processor.sv
// Bench for risc_processor: GCD runs for three operand pairs, PC trace,
// debug port, halt stability and mid-program / halted resets.
module tb_risc_processor;
  logic       clk = 1'b0;
  logic       clk_en = 1'b1;
  logic       reset = 1'b0;
  logic       reset_aux = 1'b0;
  logic [9:0] addr_a = '0, addr_b = '0, addr_c = '0;
  logic [15:0] out_a, out_b, out_c;

  int total = 0;
  int bad = 0;

  risc_processor dut (
    .clk(clk), .reset(reset), .inaddress(addr_a), .outdata(out_a)
  );
  risc_processor #(.OP_A_INIT(35), .OP_B_INIT(14)) dut_b (
    .clk(clk), .reset(reset_aux), .inaddress(addr_b), .outdata(out_b)
  );
  risc_processor #(.OP_A_INIT(9), .OP_B_INIT(9)) dut_c (
    .clk(clk), .reset(reset_aux), .inaddress(addr_c), .outdata(out_c)
  );

  // Free-running clock that can be frozen low via clk_en.
  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    int sel;
    int addr;
    int exp;
  } vec_t;

  vec_t vecs[8];
  int   trace_a[24];
  int   trace_c[5];
  int   regs_end[8];

  initial begin
    logic [15:0] got;
    bit          done;

    // Expected PC after each edge for 48,18 and for 9,9.
    trace_a  = '{1, 2, 3, 4, 7, 8, 2, 3, 4, 7, 8, 2, 3, 4, 5, 6, 2, 3, 4, 7, 8, 2, 9, 10};
    trace_c  = '{1, 2, 9, 10, 10};
    // Final registers for 48,18: r1=r2=gcd, r3 left at 1 by the last SLT.
    regs_end = '{0, 6, 6, 1, 0, 0, 0, 0};
    // Debug-port reads after the runs complete.
    vecs[0] = '{0, 0, 48};
    vecs[1] = '{0, 1, 18};
    vecs[2] = '{0, 2, 6};
    vecs[3] = '{0, 3, 0};
    vecs[4] = '{1, 0, 35};
    vecs[5] = '{1, 1, 14};
    vecs[6] = '{1, 2, 7};
    vecs[7] = '{2, 2, 9};

    // Power-up state before any clock edge, no reset applied.
    #1;
    check("powerup pc", 32'(dut.dpath.pc), 0);
    check("powerup halted", 32'(dut.dpath.halted), 0);
    addr_a = 10'd0; #1;
    check("powerup dmem0", 32'(out_a), 48);
    addr_a = 10'd2; #1;
    check("powerup dmem2", 32'(out_a), 0);

    // Cycle-by-cycle PC trace, r0 protection, and the equal-operand run.
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      check($sformatf("pc trace a[%0d]", i), 32'(dut.dpath.pc), 32'(trace_a[i]));
      check($sformatf("r0 zero [%0d]", i), 32'(dut.dpath.rbank.regfile[0]), 0);
      if (i < 5)
        check($sformatf("pc trace c[%0d]", i), 32'(dut_c.dpath.pc), 32'(trace_c[i]));
      if (i == 4)
        check("c dmem2 after 5 instr", 32'(dut_c.dpath.dmem.dmem[2]), 9);
    end
    repeat (76) @(negedge clk);

    // Table-driven debug reads across the three instances.
    for (int i = 0; i < 8; i++) begin
      addr_a = 10'(vecs[i].addr);
      addr_b = 10'(vecs[i].addr);
      addr_c = 10'(vecs[i].addr);
      #1;
      case (vecs[i].sel)
        0:       got = out_a;
        1:       got = out_b;
        default: got = out_c;
      endcase
      check($sformatf("dbg dut%0d addr%0d", vecs[i].sel, vecs[i].addr), 32'(got), 32'(vecs[i].exp));
    end
    check("final pc", 32'(dut.dpath.pc), 10);
    check("final halted", 32'(dut.dpath.halted), 1);
    for (int r = 0; r < 8; r++)
      check($sformatf("final r%0d", r), 32'(dut.dpath.rbank.regfile[r]), 32'(regs_end[r]));

    // Halt stability over 200 further cycles.
    repeat (200) @(negedge clk);
    check("halt pc", 32'(dut.dpath.pc), 10);
    check("halt dmem0", 32'(dut.dpath.dmem.dmem[0]), 48);
    check("halt dmem1", 32'(dut.dpath.dmem.dmem[1]), 18);
    check("halt dmem2", 32'(dut.dpath.dmem.dmem[2]), 6);
    for (int r = 0; r < 8; r++)
      check($sformatf("halt r%0d", r), 32'(dut.dpath.rbank.regfile[r]), 32'(regs_end[r]));

    // Debug port with the clock frozen low.
    clk_en = 1'b0;
    #2 addr_a = 10'd0;
    #1 check("frozen dbg addr0", 32'(out_a), 48);
    addr_a = 10'd2;
    #1 check("frozen dbg addr2", 32'(out_a), 6);
    check("frozen clk low", 32'(clk), 0);
    #20 clk_en = 1'b1;

    // Reset while halted.
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    check("rst halted pc", 32'(dut.dpath.pc), 0);
    check("rst halted flag", 32'(dut.dpath.halted), 0);
    check("rst halted dmem2", 32'(dut.dpath.dmem.dmem[2]), 0);
    check("rst halted dmem0", 32'(dut.dpath.dmem.dmem[0]), 48);
    for (int r = 0; r < 8; r++)
      check($sformatf("rst halted r%0d", r), 32'(dut.dpath.rbank.regfile[r]), 0);

    // Five instructions in, mid-loop, then reset again.
    repeat (5) @(negedge clk);
    check("mid pc", 32'(dut.dpath.pc), 7);
    check("mid r1", 32'(dut.dpath.rbank.regfile[1]), 48);
    check("mid r2", 32'(dut.dpath.rbank.regfile[2]), 18);
    check("mid r3", 32'(dut.dpath.rbank.regfile[3]), 1);
    reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    check("rst mid pc", 32'(dut.dpath.pc), 0);
    check("rst mid r1", 32'(dut.dpath.rbank.regfile[1]), 0);
    check("rst mid r3", 32'(dut.dpath.rbank.regfile[3]), 0);
    check("rst mid dmem2", 32'(dut.dpath.dmem.dmem[2]), 0);

    // Rerun to completion within a bounded number of cycles.
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (dut.dpath.halted) done = 1'b1;
    end
    check("rerun halted in time", 32'(done), 1);
    addr_a = 10'd2; #1;
    check("rerun dmem2", 32'(out_a), 6);
    check("rerun pc", 32'(dut.dpath.pc), 10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
